// File: rtl/inc_pulse_pkg.sv
// Shared types and constants for the button-to-increment conditioning stage.
package inc_pulse_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 256;
  localparam int DEF_REPEAT_PERIOD   = 64;

  typedef enum logic [2:0] {
    IDLE,
    ARMING,
    PRESSED,
    REPEATING,
    RELEASING
  } state_e;

  // Counter width large enough to hold the largest terminal count without wrapping.
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; q is the last stage.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw level one stage deeper each clock.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // Synchronizer flops, cleared asynchronously.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) chain_q <= '0;
    else             chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/inc_pulse_gen.sv
// Push-button conditioner: synchronize, debounce, then emit single-cycle
// increment pulses on press, with optional hold-to-repeat.
module inc_pulse_gen
  import inc_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic async_reset,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic inc,
  output logic btn_level
);

  localparam int W = timer_w(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] DB_TC    = W'(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] DELAY_TC = W'(REPEAT_DELAY - 1);
  localparam logic [W-1:0] PER_TC   = W'(REPEAT_PERIOD - 1);

  logic         s;
  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] tmr_q, tmr_d;
  logic         inc_q, inc_d;
  logic         lvl_q, lvl_d;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == '1) ? v : v + ONE;
  endfunction

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .async_reset(async_reset),
    .d          (btn_raw),
    .q          (s)
  );

  // Next-state, debounce/repeat timers and registered outputs, driven only by s.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    inc_d   = 1'b0;
    lvl_d   = lvl_q;
    unique case (state_q)
      IDLE: begin
        lvl_d = 1'b0;
        cnt_d = '0;
        tmr_d = '0;
        if (s) begin
          state_d = ARMING;
          cnt_d   = ONE;
        end
      end
      ARMING: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_TC) begin
          state_d = PRESSED;
          inc_d   = 1'b1;
          lvl_d   = 1'b1;
          cnt_d   = '0;
          tmr_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      PRESSED: begin
        if (repeat_en && tmr_q == DELAY_TC) begin
          // A terminal count coinciding with a release still fires.
          inc_d   = 1'b1;
          tmr_d   = '0;
          state_d = s ? REPEATING : RELEASING;
          if (!s) cnt_d = ONE;
        end else if (!s) begin
          state_d = RELEASING;
          cnt_d   = ONE;
          tmr_d   = '0;
        end else if (!repeat_en) begin
          tmr_d = '0;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      REPEATING: begin
        if (!repeat_en) begin
          tmr_d   = '0;
          state_d = s ? PRESSED : RELEASING;
          if (!s) cnt_d = ONE;
        end else if (tmr_q == PER_TC) begin
          inc_d   = 1'b1;
          tmr_d   = '0;
          state_d = s ? REPEATING : RELEASING;
          if (!s) cnt_d = ONE;
        end else if (!s) begin
          state_d = RELEASING;
          cnt_d   = ONE;
          tmr_d   = '0;
        end else begin
          tmr_d = sat_inc(tmr_q);
        end
      end
      RELEASING: begin
        if (s) begin
          // Release glitch: back to held, repeat delay starts over, no pulse.
          state_d = PRESSED;
          cnt_d   = '0;
          tmr_d   = '0;
        end else if (cnt_q >= DB_TC) begin
          state_d = IDLE;
          lvl_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tmr_d   = '0;
        lvl_d   = 1'b0;
      end
    endcase
  end

  // State, timers and outputs; reset drops outputs immediately.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      inc_q   <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      inc_q   <= inc_d;
      lvl_q   <= lvl_d;
    end
  end

  assign inc       = inc_q;
  assign btn_level = lvl_q;

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Directed bench for inc_pulse_gen with short debounce/repeat constants.
// Cycle n is the interval after the nth rising edge following reset release;
// inputs for edge n are driven 1ns after edge n-1, outputs sampled 1ns after edge n.
module tb_inc_pulse_gen;

  logic clk;
  logic async_reset;
  logic btn_raw;
  logic repeat_en;
  logic inc;
  logic btn_level;

  int checks;
  int failures;

  inc_pulse_gen #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .inc        (inc),
    .btn_level  (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    async_reset = 1'b1;
    btn_raw     = 1'b0;
    repeat_en   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    async_reset = 1'b0;
  endtask

  task automatic test_reset();
    async_reset = 1'b1;
    btn_raw     = 1'b1;
    repeat_en   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (inc !== 1'b0 || btn_level !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d inc=%b btn_level=%b want 0/0", i, inc, btn_level);
      end
    end
    do_reset();
  endtask

  task automatic test_clean_press();
    logic ei, el;
    do_reset();
    for (int n = 1; n <= 45; n++) begin
      btn_raw   = (n >= 10 && n <= 30);
      repeat_en = 1'b0;
      @(posedge clk);
      #1;
      ei = (n == 16);
      el = (n >= 16 && n <= 36);
      checks++;
      if (inc !== ei) begin
        failures++;
        $display("FAIL clean_inc cyc=%0d got %b want %b", n, inc, ei);
      end
      checks++;
      if (btn_level !== el) begin
        failures++;
        $display("FAIL clean_level cyc=%0d got %b want %b", n, btn_level, el);
      end
    end
  endtask

  task automatic test_bounce();
    logic ei, el, b;
    do_reset();
    for (int n = 1; n <= 55; n++) begin
      b = 1'b0;
      if (n >= 32 && n <= 34) b = 1'b1;
      if (n >= 36 && n <= 38) b = 1'b1;
      if (n >= 40) b = 1'b1;
      btn_raw   = b;
      repeat_en = 1'b0;
      @(posedge clk);
      #1;
      ei = (n == 46);
      el = (n >= 46);
      checks++;
      if (inc !== ei) begin
        failures++;
        $display("FAIL bounce_inc cyc=%0d got %b want %b", n, inc, ei);
      end
      checks++;
      if (btn_level !== el) begin
        failures++;
        $display("FAIL bounce_level cyc=%0d got %b want %b", n, btn_level, el);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic ei, el;
    int   pulses;
    pulses = 0;
    do_reset();
    for (int n = 1; n <= 90; n++) begin
      btn_raw   = (n >= 10 && n <= 70);
      repeat_en = 1'b1;
      @(posedge clk);
      #1;
      ei = (n == 16 || n == 36 || n == 44 || n == 52 || n == 60 || n == 68);
      el = (n >= 16 && n <= 76);
      if (inc === 1'b1) pulses++;
      checks++;
      if (inc !== ei) begin
        failures++;
        $display("FAIL repeat_inc cyc=%0d got %b want %b", n, inc, ei);
      end
      checks++;
      if (btn_level !== el) begin
        failures++;
        $display("FAIL repeat_level cyc=%0d got %b want %b", n, btn_level, el);
      end
    end
    checks++;
    if (pulses !== 6) begin
      failures++;
      $display("FAIL repeat_count got %0d want 6", pulses);
    end
  endtask

  task automatic test_release_glitch();
    logic ei, el;
    do_reset();
    for (int n = 1; n <= 90; n++) begin
      btn_raw   = (n >= 10 && n <= 70) && !(n == 40 || n == 41);
      repeat_en = 1'b1;
      @(posedge clk);
      #1;
      ei = (n == 16 || n == 36 || n == 64 || n == 72);
      el = (n >= 16 && n <= 76);
      checks++;
      if (inc !== ei) begin
        failures++;
        $display("FAIL glitch_inc cyc=%0d got %b want %b", n, inc, ei);
      end
      checks++;
      if (btn_level !== el) begin
        failures++;
        $display("FAIL glitch_level cyc=%0d got %b want %b", n, btn_level, el);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic ei, el;
    do_reset();
    for (int n = 1; n <= 45; n++) begin
      btn_raw   = (n >= 10);
      repeat_en = 1'b0;
      @(posedge clk);
      #1;
      ei = (n == 16 || n == 33);
      el = (n >= 16 && n <= 25) || (n >= 33);
      checks++;
      if (inc !== ei) begin
        failures++;
        $display("FAIL rst_hold_inc cyc=%0d got %b want %b", n, inc, ei);
      end
      checks++;
      if (btn_level !== el) begin
        failures++;
        $display("FAIL rst_hold_level cyc=%0d got %b want %b", n, btn_level, el);
      end
      if (n == 25) begin
        async_reset = 1'b1;
        #1;
        checks++;
        if (inc !== 1'b0 || btn_level !== 1'b0) begin
          failures++;
          $display("FAIL rst_immediate inc=%b btn_level=%b want 0/0", inc, btn_level);
        end
      end
      if (n == 26) async_reset = 1'b0;
    end
  endtask

  task automatic test_repeat_toggle();
    logic ei, el;
    do_reset();
    for (int n = 1; n <= 90; n++) begin
      btn_raw   = (n >= 10 && n <= 74);
      repeat_en = !(n >= 41 && n <= 50);
      @(posedge clk);
      #1;
      ei = (n == 16 || n == 36 || n == 70);
      el = (n >= 16 && n <= 80);
      checks++;
      if (inc !== ei) begin
        failures++;
        $display("FAIL toggle_inc cyc=%0d got %b want %b", n, inc, ei);
      end
      checks++;
      if (btn_level !== el) begin
        failures++;
        $display("FAIL toggle_level cyc=%0d got %b want %b", n, btn_level, el);
      end
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    async_reset = 1'b1;
    btn_raw     = 1'b0;
    repeat_en   = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_glitch();
    test_reset_mid_hold();
    test_repeat_toggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
